nvram_upload_reader: RTL and testbench

- Serves the HPS upload (core→HPS) direction of the ioctl file channel: streams a window of game RAM (hiscore/NVRAM) out on ioctl_din when the HPS issues ioctl_rd strobes.
- Sits beside hps_io in emu, on clk_sys. It pauses the game core, reads RAM through a request/acknowledge port, and holds off the HPS with ioctl_wait until each byte is valid.

---
 rtl/nvram_upload_reader.sv | 206 ++++++++++++++++++++
 tb/tb_nvram_upload_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader
//
// Upload (core -> HPS) side of the ioctl file channel. When the HPS opens an
// upload on UPLOAD_INDEX, the game core is paused and a window of game RAM
// (hiscore / NVRAM) is streamed out one byte per ioctl_rd strobe. ioctl_wait
// holds the HPS off until ioctl_din is valid for the next address.
//
// Ports
//   clk_sys       system clock, single domain
//   reset_n       asynchronous active-low reset
//   ioctl_upload  upload in progress (level from hps_io)
//   ioctl_index   file index of the transfer
//   ioctl_rd      strobe: HPS consumed ioctl_din for ioctl_addr
//   ioctl_addr    byte address of the current transfer
//   ioctl_din     byte presented to the HPS
//   ioctl_wait    high while ioctl_din is not yet valid
//   pause_req     halt request to the game CPU
//   pause_ack     core halted, RAM safe to read
//   ram_addr      RAM read address
//   ram_rd        RAM read request, held until ack or timeout
//   ram_ack       one-cycle ack, ram_data valid in the same cycle
//   ram_data      RAM read data
//   err           sticky timeout flag, cleared when the next upload starts
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no upload, core running, waiting for active to rise
// S_PAUSE | pause requested, waiting for pause_ack
// S_ISSUE | decide padding vs RAM read for next_addr
// S_FETCH | ram_rd held, waiting for ram_ack or timeout
// S_READY | ioctl_din valid, wait low, waiting for ioctl_rd

module nvram_upload_reader #(
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         AW           = 10,
    parameter logic [7:0] PAD          = 8'hFF,
    parameter int         TIMEOUT      = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic          ram_ack,
    input  logic [7:0]    ram_data,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_ISSUE,
        S_FETCH,
        S_READY
    } state_t;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LOAD = CW'(TIMEOUT - 1);
    // Window size as a 26-bit value so AW up to 25 compares correctly.
    localparam logic [25:0]    WIN_SIZE = 26'd1 << AW;

    state_t         state, state_n;
    logic           active, active_q;
    logic [24:0]    next_addr, next_addr_n;
    logic [CW-1:0]  tmo_cnt, tmo_cnt_n;
    logic           abort_pend, abort_pend_n;
    logic [7:0]     din_n;
    logic           wait_n, pause_n, ram_rd_n, err_n;
    logic [AW-1:0]  ram_addr_n;
    logic           out_of_range;

    assign active       = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
    assign out_of_range = ({1'b0, next_addr} >= WIN_SIZE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            active_q   <= 1'b0;
            next_addr  <= '0;
            tmo_cnt    <= '0;
            abort_pend <= 1'b0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            active_q   <= active;
            next_addr  <= next_addr_n;
            tmo_cnt    <= tmo_cnt_n;
            abort_pend <= abort_pend_n;
            ioctl_din  <= din_n;
            ioctl_wait <= wait_n;
            pause_req  <= pause_n;
            ram_addr   <= ram_addr_n;
            ram_rd     <= ram_rd_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        next_addr_n  = next_addr;
        tmo_cnt_n    = tmo_cnt;
        abort_pend_n = abort_pend;
        din_n        = ioctl_din;
        wait_n       = ioctl_wait;
        pause_n      = pause_req;
        ram_addr_n   = ram_addr;
        ram_rd_n     = ram_rd;
        err_n        = err;

        case (state)
            S_IDLE: begin
                if (active && !active_q) begin
                    pause_n      = 1'b1;
                    wait_n       = 1'b1;
                    err_n        = 1'b0;
                    next_addr_n  = '0;
                    abort_pend_n = 1'b0;
                    state_n      = S_PAUSE;
                end
            end

            S_PAUSE: begin
                if (!active) begin
                    pause_n = 1'b0;
                    wait_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (pause_ack) begin
                    state_n = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!active) begin
                    pause_n = 1'b0;
                    wait_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (out_of_range) begin
                    din_n   = PAD;
                    wait_n  = 1'b0;
                    state_n = S_READY;
                end else begin
                    ram_addr_n = next_addr[AW-1:0];
                    ram_rd_n   = 1'b1;
                    tmo_cnt_n  = TMO_LOAD;
                    state_n    = S_FETCH;
                end
            end

            S_FETCH: begin
                // An upload that ends mid-read is remembered so the RAM
                // handshake still runs to completion before leaving.
                if (!active) begin
                    abort_pend_n = 1'b1;
                end
                if (ram_ack || (tmo_cnt == '0)) begin
                    ram_rd_n = 1'b0;
                    if (ram_ack) begin
                        din_n = ram_data;
                    end else begin
                        din_n = PAD;
                        err_n = 1'b1;
                    end
                    wait_n = 1'b0;
                    if (!active || abort_pend) begin
                        pause_n      = 1'b0;
                        abort_pend_n = 1'b0;
                        state_n      = S_IDLE;
                    end else begin
                        state_n = S_READY;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt - 1'b1;
                end
            end

            S_READY: begin
                if (!active) begin
                    pause_n = 1'b0;
                    wait_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (ioctl_rd) begin
                    next_addr_n = ioctl_addr + 25'd1;
                    wait_n      = 1'b1;
                    state_n     = S_ISSUE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Testbench for nvram_upload_reader (instantiated with a 16-byte window).
// A RAM responder acks reads after a programmable delay or stalls one
// address; expected bytes, latencies and flags come from a simple model of
// the window: in-range addresses return the RAM byte, anything else PAD.

module tb_nvram_upload_reader;

    localparam int         AW      = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] PAD     = 8'hFF;
    localparam int         WSIZE   = 1 << AW;

    logic          clk_sys;
    logic          reset_n;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_ack;
    logic [7:0]    ram_data;
    logic          err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:WSIZE-1];
    int ack_delay  = 0;
    int stall_addr = -1;
    int rd_cycles  = 0;
    int rd_pulses  = 0;
    int ack_count  = 0;

    nvram_upload_reader #(
        .UPLOAD_INDEX (8'd4),
        .AW           (AW),
        .PAD          (PAD),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_ack      (ram_ack),
        .ram_data     (ram_data),
        .err          (err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // RAM responder, operating on the falling edge so the DUT sees stable
    // ack/data at the next rising edge.
    initial begin : responder
        int wcnt;
        bit given;
        bit prev;
        wcnt     = 0;
        given    = 1'b0;
        prev     = 1'b0;
        ram_ack  = 1'b0;
        ram_data = 8'h00;
        forever begin
            @(negedge clk_sys);
            ram_ack = 1'b0;
            if (ram_rd === 1'b1) begin
                rd_cycles++;
                if (!prev) rd_pulses++;
                if (!given && (stall_addr != int'(ram_addr))) begin
                    if (wcnt >= ack_delay) begin
                        ram_ack  = 1'b1;
                        ram_data = mem[ram_addr];
                        given    = 1'b1;
                        ack_count++;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt  = 0;
                given = 1'b0;
            end
            prev = (ram_rd === 1'b1);
        end
    end

    function automatic logic [7:0] model_byte(input logic [24:0] a);
        if (a < 25'(WSIZE)) return mem[a[AW-1:0]];
        return PAD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ioctl_wait === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(ioctl_wait), 32'd0);
    endtask

    // HPS consumes the byte for addr; DUT must present the byte for addr+1.
    task automatic read_next(input string tag, input logic [24:0] addr,
                             input logic [7:0] exp_din, input int exp_lat);
        int lat;
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        ioctl_rd   = 1'b0;
        ioctl_addr = 25'($urandom);
        lat = 1;
        check({tag, "_wait_rise"}, 32'(ioctl_wait), 32'd1);
        while (ioctl_wait === 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_din"}, 32'(ioctl_din), 32'(exp_din));
    endtask

    task automatic open_upload(input string tag, input int pdelay);
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        tick();
        check({tag, "_pause_rise"}, 32'({pause_req, ioctl_wait}), 32'b11);
        // strobes during PAUSE must not move the start address
        repeat (pdelay) begin
            ioctl_rd   = 1'b1;
            ioctl_addr = 25'd9;
            tick();
            ioctl_rd   = 1'b0;
        end
        check({tag, "_wait_in_pause"}, 32'(ioctl_wait), 32'd1);
        pause_ack = 1'b1;
        wait_ready({tag, "_first_bound"});
        check({tag, "_first_din"}, 32'(ioctl_din), 32'(model_byte(25'd0)));
    endtask

    task automatic close_upload(input string tag);
        ioctl_upload = 1'b0;
        tick();
        tick();
        check({tag, "_released"}, 32'({pause_req, ioctl_wait}), 32'b00);
        pause_ack = 1'b0;
        tick();
    endtask

    initial begin : main
        int p0, c0, a0, d, sel;
        logic [24:0] tgt;
        bit seen, held;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        pause_ack    = 1'b0;
        for (int i = 0; i < WSIZE; i++) mem[i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_values", 32'({ioctl_din, ioctl_wait, pause_req, ram_rd, ram_addr, err}), 32'd0);
        reset_n = 1'b1;
        tick();

        // basic stream 0..7
        ack_delay = 0;
        open_upload("basic", 5);
        for (int a = 0; a < 7; a++)
            read_next("basic", 25'(a), model_byte(25'(a + 1)), 3);
        check("basic_err", 32'(err), 32'd0);
        close_upload("basic");

        // wrong index: nothing happens
        p0 = rd_pulses;
        seen = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_upload = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ioctl_rd   = i[0];
            ioctl_addr = 25'(i);
            tick();
            seen |= pause_req | ioctl_wait | ram_rd;
        end
        ioctl_rd = 1'b0;
        check("wrong_idx_quiet", 32'(seen), 32'd0);
        check("wrong_idx_no_ram", 32'(rd_pulses - p0), 32'd0);
        ioctl_upload = 1'b0;
        tick();

        // padding across the window edge, then 25-bit wrap and high bits
        ack_delay = 1;
        open_upload("pad", 2);
        read_next("pad14", 25'd13, model_byte(25'd14), 4);
        read_next("pad15", 25'd14, model_byte(25'd15), 4);
        p0 = rd_pulses;
        read_next("pad16", 25'd15, PAD, 2);
        read_next("pad17", 25'd16, PAD, 2);
        check("pad_no_ram", 32'(rd_pulses - p0), 32'd0);
        read_next("wrap", 25'h1FF_FFFF, model_byte(25'd0), 4);
        read_next("highbits", 25'h100_0002, PAD, 2);
        read_next("top", 25'h1FF_FFFE, PAD, 2);
        close_upload("pad");

        // timeout on address 3
        for (int i = 0; i < WSIZE; i++) mem[i] = 8'($urandom);
        ack_delay  = 0;
        stall_addr = 3;
        open_upload("tmo", 0);
        read_next("tmo1", 25'd0, model_byte(25'd1), 3);
        read_next("tmo2", 25'd1, model_byte(25'd2), 3);
        c0 = rd_cycles;
        read_next("tmo3", 25'd2, PAD, TIMEOUT + 2);
        check("tmo_rd_cycles", 32'(rd_cycles - c0), 32'(TIMEOUT));
        check("tmo_err_set", 32'(err), 32'd1);
        stall_addr = -1;
        read_next("tmo4", 25'd3, model_byte(25'd4), 3);
        close_upload("tmo");
        check("tmo_err_sticky", 32'(err), 32'd1);

        // next upload clears err; randomized addresses and ack delays
        for (int i = 0; i < WSIZE; i++) mem[i] = 8'($urandom);
        open_upload("rnd", 1);
        check("rnd_err_cleared", 32'(err), 32'd0);
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(0, 4);
            ack_delay = d;
            sel = $urandom_range(0, 3);
            case (sel)
                0, 1:    tgt = 25'($urandom_range(0, WSIZE - 1));
                2:       tgt = 25'($urandom_range(WSIZE, WSIZE + 24));
                default: tgt = 25'($urandom);
            endcase
            read_next("rnd", tgt - 25'd1, model_byte(tgt),
                      (tgt < 25'(WSIZE)) ? (3 + d) : 2);
        end
        check("rnd_err", 32'(err), 32'd0);

        // abort while a RAM read is outstanding
        ack_delay  = 5;
        a0         = ack_count;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd4;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        check("abort_rd_started", 32'(ram_rd), 32'd1);
        ioctl_upload = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            held &= ram_rd & pause_req;
        end
        check("abort_rd_held", 32'(held), 32'd1);
        for (int i = 0; i < 30 && ram_rd === 1'b1; i++) tick();
        check("abort_acked", 32'(ack_count - a0), 32'd1);
        check("abort_idle", 32'({ram_rd, pause_req, ioctl_wait, err}), 32'd0);
        pause_ack = 1'b0;
        tick();
        check("abort_stays_idle", 32'({pause_req, ioctl_wait}), 32'd0);

        // asynchronous reset during FETCH
        ack_delay  = 0;
        stall_addr = 5;
        open_upload("arst", 0);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd4;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        check("arst_in_fetch", 32'(ram_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_async_clear", 32'({pause_req, ram_rd, ioctl_wait, err, ioctl_din}), 32'd0);
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        stall_addr   = -1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("arst_after", 32'({pause_req, ram_rd, ioctl_wait}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
